column_evaluator: RTL and testbench

- Read-side sequencer for the worksheet argument stores.
- After a start pulse, sweeps the column index from 0 to last_col.
- For each column, samples the three row operands and that column's operator, then evaluates the column as a sum or a product.
- Accumulates all column results into a grand total and reports it with a one-cycle done pulse; sits between the argument/operator stores and the result output logic.

---
 rtl/column_evaluator_if.sv | 25 ++
 rtl/column_evaluator.sv | 95 +++++++++
 tb/tb_column_evaluator.sv | 130 +++++++++++++
 3 files changed

// File: rtl/column_evaluator_if.sv
// column_evaluator_if: start/done handshake, result, and column read port toward the argument/operator stores.
interface column_evaluator_if #(
  parameter int ARG_COL_WIDTH  = 10,
  parameter int ARG_DATA_WIDTH = 16,
  parameter int RESULT_WIDTH   = 64
);
  logic                      start;
  logic [ARG_COL_WIDTH-1:0]  last_col;
  logic                      busy;
  logic                      done;
  logic [RESULT_WIDTH-1:0]   total;
  logic [ARG_COL_WIDTH-1:0]  rd_arg_col;
  logic [ARG_DATA_WIDTH-1:0] rd_arg_data_row0;
  logic [ARG_DATA_WIDTH-1:0] rd_arg_data_row1;
  logic [ARG_DATA_WIDTH-1:0] rd_arg_data_row2;
  logic                      rd_op_mul;
  modport slave (
    input  start, last_col, rd_arg_data_row0, rd_arg_data_row1, rd_arg_data_row2, rd_op_mul,
    output busy, done, total, rd_arg_col
  );
  modport master (
    output start, last_col, rd_arg_data_row0, rd_arg_data_row1, rd_arg_data_row2, rd_op_mul,
    input  busy, done, total, rd_arg_col
  );
endinterface

// File: rtl/column_evaluator.sv
// column_evaluator: sweeps columns 0..last_col, evaluates each as sum or product of three rows, accumulates a grand total.
module column_evaluator #(
  parameter int ARG_COL_WIDTH  = 10,
  parameter int ARG_DATA_WIDTH = 16,
  parameter int RESULT_WIDTH   = 64
) (
  input logic clk,
  input logic reset,
  column_evaluator_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, ACC, DONE} state_t;
  state_t state_q, state_d;
  logic [ARG_COL_WIDTH-1:0] col_q, col_d, last_q, last_d;
  logic [ARG_DATA_WIDTH-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
  logic op_q, op_d;
  logic [RESULT_WIDTH-1:0] part_q, part_d, acc_q, acc_d, total_q, total_d;
  logic [RESULT_WIDTH-1:0] a, b, c;
  logic last_hit;
  assign a = RESULT_WIDTH'(r0_q);
  assign b = RESULT_WIDTH'(r1_q);
  assign c = RESULT_WIDTH'(r2_q);
  assign last_hit = col_q == last_q;
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    last_d  = last_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    op_d    = op_q;
    part_d  = part_q;
    acc_d   = acc_q;
    total_d = total_q;
    case (state_q)
      IDLE: if (bus.start) begin
        last_d  = bus.last_col;
        col_d   = '0;
        acc_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        r0_d    = bus.rd_arg_data_row0;
        r1_d    = bus.rd_arg_data_row1;
        r2_d    = bus.rd_arg_data_row2;
        op_d    = bus.rd_op_mul;
        state_d = EVAL;
      end
      EVAL: begin
        part_d  = op_q ? a * b * c : a + b + c;
        state_d = ACC;
      end
      // compare before incrementing so the top column index never wraps the counter
      ACC: begin
        acc_d   = acc_q + part_q;
        col_d   = last_hit ? col_q : col_q + 1'b1;
        state_d = last_hit ? DONE : LOAD;
      end
      DONE: begin
        total_d = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      last_q  <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      op_q    <= 1'b0;
      part_q  <= '0;
      acc_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      last_q  <= last_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      op_q    <= op_d;
      part_q  <= part_d;
      acc_q   <= acc_d;
      total_q <= total_d;
    end
  end
  // total_d already carries the final sum during DONE, so the result shows in the done cycle itself
  assign bus.total      = total_d;
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = state_q == DONE;
  assign bus.rd_arg_col = col_q;
endmodule

// File: tb/tb_column_evaluator.sv
// tb_column_evaluator: randomized and directed runs checked against an arithmetic reference of the column sweep.
module tb_column_evaluator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  longint unsigned prev_total = 0;
  logic [15:0] m0 [1024];
  logic [15:0] m1 [1024];
  logic [15:0] m2 [1024];
  logic        mop [1024];
  column_evaluator_if bus ();
  column_evaluator dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.rd_arg_data_row0 = m0[bus.rd_arg_col];
  assign bus.rd_arg_data_row1 = m1[bus.rd_arg_col];
  assign bus.rd_arg_data_row2 = m2[bus.rd_arg_col];
  assign bus.rd_op_mul        = mop[bus.rd_arg_col];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint unsigned model(input int last);
    longint unsigned sum = 0;
    for (int k = 0; k <= last; k++)
      sum += mop[k] ? longint'(m0[k]) * longint'(m1[k]) * longint'(m2[k])
                    : longint'(m0[k]) + longint'(m1[k]) + longint'(m2[k]);
    return sum;
  endfunction
  task automatic set_col(input int k, input int x, input int y, input int z, input bit mul);
    m0[k] = 16'(x); m1[k] = 16'(y); m2[k] = 16'(z); mop[k] = mul;
  endtask
  task automatic set_worked();
    set_col(0, 123, 45, 6, 1);
    set_col(1, 328, 64, 98, 0);
    set_col(2, 51, 387, 215, 1);
    set_col(3, 64, 23, 314, 0);
  endtask
  // entered and left #1 after a rising edge in an idle cycle; inj > 0 pulses a stray start in that cycle
  task automatic run(input int last, input longint unsigned exp, input int inj);
    int cyc;
    bus.start = 1'b1;
    bus.last_col = 10'(last);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    chk("total_kept_on_start", bus.total, prev_total);
    while (!bus.done && cyc < 3 * (last + 1) + 10) begin
      chk("busy", bus.busy, 1);
      if (cyc % 3 == 1) chk("rd_arg_col", bus.rd_arg_col, (cyc - 1) / 3);
      bus.start = (cyc == inj);
      if (cyc == inj) bus.last_col = 10'(last + 5);
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_cycle", cyc, 3 * (last + 1) + 1);
    chk("total", bus.total, exp);
    chk("busy_in_done", bus.busy, 1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("total_held", bus.total, exp);
    prev_total = exp;
  endtask
  initial begin
    int seen;
    int last;
    bus.start = 1'b0;
    bus.last_col = '0;
    for (int k = 0; k < 1024; k++) set_col(k, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_col", bus.rd_arg_col, 0);
    chk("rst_total", bus.total, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    set_col(0, 2, 3, 4, 0);
    run(0, 64'd9, -1);
    set_worked();
    run(3, 64'd4277556, -1);
    set_col(0, 65535, 65535, 65535, 1);
    run(0, 64'd281462092005375, -1);
    set_worked();
    run(3, 64'd4277556, 5);
    set_col(0, 7, 0, 9, 1);
    set_col(1, 0, 0, 0, 0);
    set_col(2, 10, 20, 30, 0);
    run(2, 64'd60, -1);
    set_worked();
    bus.start = 1'b1;
    bus.last_col = 10'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_col", bus.rd_arg_col, 0);
    chk("arst_total", bus.total, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    prev_total = 0;
    run(3, 64'd4277556, -1);
    for (int r = 0; r < 8; r++) begin
      last = int'($urandom_range(0, 15));
      for (int k = 0; k <= last; k++)
        set_col(k, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      run(last, model(last), (r == 3) ? 4 : -1);
    end
    for (int k = 0; k < 1024; k++) set_col(k, 1, 1, 1, 0);
    run(1023, 64'd3072, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
